lector_resultados_bcd: RTL and testbench



---
 rtl/lector_resultados_bcd_if.sv | 22 ++
 rtl/lector_resultados_bcd.sv | 167 ++++++++++++++++
 tb/tb_lector_resultados_bcd.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/lector_resultados_bcd_if.sv
// Read-port bundle between the SPI controller and the BCD result reader.
// Signal suffixes are named from the reader's point of view.
interface lector_resultados_bcd_if #(
  parameter int unsigned ADDR_W = 10
) ();
  logic              done_i;
  logic [ADDR_W-1:0] n_i;
  logic [31:0]       dato_i;
  logic [ADDR_W-1:0] rd_addr_o;
  logic              reg_sel_o;
  logic              rd_en_o;

  modport master (
    input  done_i, n_i, dato_i,
    output rd_addr_o, reg_sel_o, rd_en_o
  );

  modport slave (
    output done_i, n_i, dato_i,
    input  rd_addr_o, reg_sel_o, rd_en_o
  );
endinterface

// File: rtl/lector_resultados_bcd.sv
// Walks the SPI receive bank after each transfer, converts every byte to three
// BCD digits with a sequential double-dabble and holds each entry for a dwell time.
module lector_resultados_bcd #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter int unsigned RD_LAT       = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  lector_resultados_bcd_if.master ctl,
  output logic [11:0]           bcd_o,
  output logic [ADDR_W-1:0]     idx_o,
  output logic                  valido_o,
  output logic                  busy_o
);

  // Shared counter covers both the read-latency wait and the dwell time.
  localparam int unsigned CNT_W = $clog2(DWELL_CYCLES + 2);
  localparam int unsigned SH_W  = 20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CONV,
    S_SHOW
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        it_q, it_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_en_q, rd_en_d;
  logic [11:0]       bcd_q, bcd_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              valido_q, valido_d;
  logic              busy_q, busy_d;
  logic [SH_W-1:0]   step_c;
  logic              unused_dato_c;

  // One double-dabble iteration: bias digits >= 5 by 3, then shift left.
  function automatic logic [SH_W-1:0] dd_step(input logic [SH_W-1:0] s);
    logic [SH_W-1:0] t;
    t = s;
    for (int d = 0; d < 3; d++) begin
      if (t[8+4*d +: 4] >= 4'd5) t[8+4*d +: 4] = t[8+4*d +: 4] + 4'd3;
    end
    return {t[SH_W-2:0], 1'b0};
  endfunction

  assign step_c        = dd_step(sh_q);
  assign unused_dato_c = ^ctl.dato_i[31:8];

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    index_d   = index_q;
    cnt_d     = cnt_q;
    it_d      = it_q;
    sh_d      = sh_q;
    rd_addr_d = rd_addr_q;
    rd_en_d   = 1'b0;
    bcd_d     = bcd_q;
    idx_d     = idx_q;
    valido_d  = valido_q;

    case (state_q)
      S_READ: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(RD_LAT - 1)) begin
          sh_d    = {12'd0, ctl.dato_i[7:0]};
          it_d    = 3'd0;
          state_d = S_CONV;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CONV: begin
        sh_d = step_c;
        it_d = it_q + 3'd1;
        if (it_q == 3'd7) begin
          bcd_d    = step_c[SH_W-1:8];
          idx_d    = index_q;
          valido_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_SHOW;
        end
      end
      S_SHOW: begin
        if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
          index_d = (index_q == n_q - ADDR_W'(1)) ? '0 : index_q + ADDR_W'(1);
          state_d = S_READ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase

    // A new transfer overrides whatever is in progress, dwell expiry included.
    if (ctl.done_i) begin
      n_d     = ctl.n_i;
      index_d = '0;
      cnt_d   = '0;
      it_d    = 3'd0;
      if (ctl.n_i == '0) begin
        state_d  = S_IDLE;
        bcd_d    = '0;
        idx_d    = '0;
        valido_d = 1'b0;
      end else begin
        state_d = S_READ;
      end
    end

    if (state_d == S_READ) begin
      rd_en_d   = 1'b1;
      rd_addr_d = index_d;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      index_q   <= '0;
      cnt_q     <= '0;
      it_q      <= 3'd0;
      sh_q      <= '0;
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      bcd_q     <= '0;
      idx_q     <= '0;
      valido_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      index_q   <= index_d;
      cnt_q     <= cnt_d;
      it_q      <= it_d;
      sh_q      <= sh_d;
      rd_addr_q <= rd_addr_d;
      rd_en_q   <= rd_en_d;
      bcd_q     <= bcd_d;
      idx_q     <= idx_d;
      valido_q  <= valido_d;
      busy_q    <= busy_d;
    end
  end

  assign ctl.rd_addr_o = rd_addr_q;
  assign ctl.reg_sel_o = 1'b1;
  assign ctl.rd_en_o   = rd_en_q;
  assign bcd_o         = bcd_q;
  assign idx_o         = idx_q;
  assign valido_o      = valido_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_lector_resultados_bcd.sv
// Scoreboard bench for lector_resultados_bcd: a bank model answers reads and
// each read strobe schedules the expected BCD result RD_LAT+9 cycles later.
module tb_lector_resultados_bcd;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DWELL  = 4;
  localparam int unsigned RD_LAT = 1;
  localparam int          LAT    = RD_LAT + 9;

  typedef struct {
    logic [11:0]       bcd;
    logic [ADDR_W-1:0] idx;
    int                due;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [11:0]       bcd_o;
  logic [ADDR_W-1:0] idx_o;
  logic              valido_o;
  logic              busy_o;

  logic [7:0]        bank [0:15];
  exp_t              sbq [$];
  exp_t              mon_e;
  int                cyc = 0;
  int                n_cmp = 0;
  int                n_err = 0;
  int                rd_cnt = 0;
  int                last_rd = 0;
  bit                chk_period = 1'b0;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [ADDR_W-1:0] exp_n = '0;
  logic [11:0]       shown_bcd = '0;
  logic [ADDR_W-1:0] shown_idx = '0;

  lector_resultados_bcd_if #(.ADDR_W(ADDR_W)) bus ();

  lector_resultados_bcd #(
    .ADDR_W      (ADDR_W),
    .DWELL_CYCLES(DWELL),
    .RD_LAT      (RD_LAT)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .ctl      (bus),
    .bcd_o    (bcd_o),
    .idx_o    (idx_o),
    .valido_o (valido_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Receive-bank model, one cycle read latency, junk in the upper bits.
  always @(posedge clk) begin
    if (bus.rd_en_o) bus.dato_i <= {24'($urandom()), bank[bus.rd_addr_o]};
  end

  function automatic logic [11:0] to_bcd(input logic [7:0] v);
    int u;
    u = int'(v);
    return {4'(u / 100), 4'((u / 10) % 10), 4'(u % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: check read address/period, schedule and retire expected results.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rd_en_o) begin
        chk("rd_addr", 32'(bus.rd_addr_o), 32'(exp_addr));
        chk("reg_sel", 32'(bus.reg_sel_o), 32'd1);
        if (chk_period) chk("reread_period", 32'(cyc - last_rd), 32'(LAT + DWELL));
        chk_period = 1'b1;
        last_rd    = cyc;
        sbq.push_back('{to_bcd(bank[exp_addr]), exp_addr, cyc + LAT});
        exp_addr = (exp_addr == exp_n - ADDR_W'(1)) ? '0 : exp_addr + ADDR_W'(1);
        rd_cnt++;
      end
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        mon_e = sbq.pop_front();
        chk("bcd", 32'(bcd_o), 32'(mon_e.bcd));
        chk("idx", 32'(idx_o), 32'(mon_e.idx));
        chk("valido", 32'(valido_o), 32'd1);
        shown_bcd = mon_e.bcd;
        shown_idx = mon_e.idx;
      end
    end
  end

  task automatic pulse_done(input logic [ADDR_W-1:0] n);
    @(negedge clk);
    #1;
    bus.done_i = 1'b1;
    bus.n_i    = n;
    sbq.delete();
    exp_addr   = '0;
    exp_n      = n;
    chk_period = 1'b0;
    @(posedge clk);
    #1;
    bus.done_i = 1'b0;
    bus.n_i    = $urandom_range(0, 15);
  endtask

  task automatic wait_rd(input int target, input int budget);
    for (int i = 0; i < budget && rd_cnt < target; i++) @(posedge clk);
    if (rd_cnt < target) chk("wait_rd_timeout", 32'(rd_cnt), 32'(target));
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sbq.size() > 0; i++) @(posedge clk);
    chk("drain", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    int base;
    rst_n      = 1'b0;
    bus.done_i = 1'b0;
    bus.n_i    = '0;
    bus.dato_i = '0;
    for (int i = 0; i < 16; i++) bank[i] = 8'(i * 17);

    #23;
    chk("rst_rd_addr", 32'(bus.rd_addr_o), 32'd0);
    chk("rst_reg_sel", 32'(bus.reg_sel_o), 32'd1);
    chk("rst_rd_en", 32'(bus.rd_en_o), 32'd0);
    chk("rst_bcd", 32'(bcd_o), 32'd0);
    chk("rst_idx", 32'(idx_o), 32'd0);
    chk("rst_valido", 32'(valido_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with no transfer
    repeat (20) @(negedge clk);
    chk("idle_rd_cnt", 32'(rd_cnt), 32'd0);
    chk("idle_busy", 32'(busy_o), 32'd0);

    // Zero-count transfer
    pulse_done('0);
    repeat (20) @(negedge clk);
    chk("zero_busy", 32'(busy_o), 32'd0);
    chk("zero_valido", 32'(valido_o), 32'd0);
    chk("zero_rd_cnt", 32'(rd_cnt), 32'd0);

    // Single entry, re-read every dwell period
    bank[0] = 8'hFF;
    pulse_done(ADDR_W'(1));
    chk("rd_en_after_done", 32'(bus.rd_en_o), 32'd1);
    chk("busy_after_done", 32'(busy_o), 32'd1);
    wait_rd(3, 100);
    wait_drain(50);
    chk("single_shown", 32'(shown_bcd), 32'h255);

    // Multi-entry wrap
    bank[0] = 8'd0;
    bank[1] = 8'd9;
    bank[2] = 8'd100;
    pulse_done(ADDR_W'(3));
    base = rd_cnt;
    wait_rd(base + 4, 200);
    wait_drain(50);
    chk("wrap_shown_idx", 32'(shown_idx), 32'd0);

    // Restart while entry 1 is converting
    base = rd_cnt;
    wait_rd(base + 1, 100);
    repeat (3) @(negedge clk);
    bank[0] = 8'd77;
    pulse_done(ADDR_W'(2));
    chk("restart_keep_bcd", 32'(bcd_o), 32'(shown_bcd));
    chk("restart_keep_idx", 32'(idx_o), 32'(shown_idx));
    chk("restart_keep_valido", 32'(valido_o), 32'd1);
    chk("restart_busy", 32'(busy_o), 32'd1);
    base = rd_cnt;
    wait_rd(base + 1, 100);
    wait_drain(50);
    chk("restart_shown", 32'(shown_bcd), 32'h077);

    // Asynchronous reset while showing
    #2;
    rst_n = 1'b0;
    sbq.delete();
    #1;
    chk("areset_bcd", 32'(bcd_o), 32'd0);
    chk("areset_idx", 32'(idx_o), 32'd0);
    chk("areset_valido", 32'(valido_o), 32'd0);
    chk("areset_busy", 32'(busy_o), 32'd0);
    chk("areset_rd_en", 32'(bus.rd_en_o), 32'd0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
